// File: rtl/io_byte_bridge.sv
// io_byte_bridge: byte buffering between the core's I/O port and a UART engine.
// Two independent show-ahead FIFOs (core->UART on TX, UART->core on RX) with
// core stall generation, occupancy counts and sticky error flags.
module io_byte_bridge #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_issued,
  input  logic [31:0]       out_data,
  output logic              out_stall,
  input  logic              in_issued,
  output logic [31:0]       in_data,
  output logic              in_stall,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [TX_AW:0]    tx_count,
  output logic [RX_AW:0]    rx_count,
  output logic              rx_overrun,
  output logic              tx_drop
);

  localparam int TX_N = 1 << TX_AW;
  localparam int RX_N = 1 << RX_AW;
  localparam logic [TX_AW:0] TX_DEPTH = (TX_AW + 1)'(TX_N);
  localparam logic [RX_AW:0] RX_DEPTH = (RX_AW + 1)'(RX_N);

  logic [7:0]       tx_mem [TX_N];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_cnt;
  logic             tx_full, tx_push, tx_pop;

  logic [7:0]       rx_mem [RX_N];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_cnt;
  logic             rx_full, rx_empty, rx_push, rx_pop;

  logic             tx_drop_q, rx_overrun_q;

  // Handshake decode; full/empty come only from registered counts so the
  // stall outputs never depend combinationally on tx_ready or rx_valid.
  always_comb begin
    tx_full  = (tx_cnt == TX_DEPTH);
    tx_push  = out_issued & ~tx_full;
    tx_pop   = (tx_cnt != '0) & tx_ready;
    rx_full  = (rx_cnt == RX_DEPTH);
    rx_empty = (rx_cnt == '0);
    rx_push  = rx_valid & ~rx_full;
    rx_pop   = in_issued & ~rx_empty;
  end

  // TX storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (rst && tx_push) tx_mem[tx_wr_ptr] <= out_data[7:0];
  end

  // TX pointers, occupancy and the protocol-violation flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (out_issued && tx_full) tx_drop_q <= 1'b1;
    end
  end

  // RX storage write from the UART receiver.
  always_ff @(posedge clk) begin
    if (rst && rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // RX pointers, occupancy and the dropped-byte flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      rx_cnt       <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      if (rx_valid && rx_full) rx_overrun_q <= 1'b1;
    end
  end

  // Show-ahead outputs and status presented to the core and the UART.
  always_comb begin
    out_stall  = tx_full;
    tx_valid   = (tx_cnt != '0);
    tx_data    = tx_mem[tx_rd_ptr];
    in_stall   = rx_empty;
    in_data    = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_ptr]};
    tx_count   = tx_cnt;
    rx_count   = rx_cnt;
    tx_drop    = tx_drop_q;
    rx_overrun = rx_overrun_q;
  end

endmodule

// File: tb/tb_io_byte_bridge.sv
// tb_io_byte_bridge: directed checks plus randomized traffic compared against
// a queue-based reference model of both byte buffers.
module tb_io_byte_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_issued;
  logic [31:0] out_data;
  logic        out_stall;
  logic        in_issued;
  logic [31:0] in_data;
  logic        in_stall;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [4:0]  tx_count;
  logic [4:0]  rx_count;
  logic        rx_overrun;
  logic        tx_drop;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_tx_drop;
  logic       m_rx_overrun;

  io_byte_bridge #(.TX_AW(4), .RX_AW(4)) dut (
    .clk(clk), .rst(rst),
    .out_issued(out_issued), .out_data(out_data), .out_stall(out_stall),
    .in_issued(in_issued), .in_data(in_data), .in_stall(in_stall),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_count(tx_count), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .tx_drop(tx_drop)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    out_issued = 1'b0;
    out_data   = '0;
    in_issued  = 1'b0;
    tx_ready   = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = '0;
  endtask

  // Compare every output against the model, then advance one clock edge and
  // apply the buffer rules to the model with the inputs seen at that edge.
  task automatic apply_stimulus();
    bit tx_full_m, rx_full_m, do_tx_pop, do_rx_pop;
    #1;
    check_output("tx_valid",  32'(tx_valid),  32'(tx_q.size() != 0));
    if (tx_q.size() != 0) check_output("tx_data", 32'(tx_data), 32'(tx_q[0]));
    check_output("tx_count",  32'(tx_count),  32'(tx_q.size()));
    check_output("out_stall", 32'(out_stall), 32'(tx_q.size() == 16));
    check_output("in_stall",  32'(in_stall),  32'(rx_q.size() == 0));
    check_output("in_data",   in_data,        (rx_q.size() == 0) ? 32'd0 : 32'(rx_q[0]));
    check_output("rx_count",  32'(rx_count),  32'(rx_q.size()));
    check_output("tx_drop",   32'(tx_drop),   32'(m_tx_drop));
    check_output("rx_overrun",32'(rx_overrun),32'(m_rx_overrun));
    @(posedge clk);
    if (!rst) begin
      tx_q.delete();
      rx_q.delete();
      m_tx_drop    = 1'b0;
      m_rx_overrun = 1'b0;
    end else begin
      tx_full_m = (tx_q.size() == 16);
      rx_full_m = (rx_q.size() == 16);
      do_tx_pop = (tx_q.size() != 0) && tx_ready;
      do_rx_pop = (rx_q.size() != 0) && in_issued;
      if (do_tx_pop) void'(tx_q.pop_front());
      if (out_issued && !tx_full_m) tx_q.push_back(out_data[7:0]);
      if (out_issued && tx_full_m) m_tx_drop = 1'b1;
      if (do_rx_pop) void'(rx_q.pop_front());
      if (rx_valid && !rx_full_m) rx_q.push_back(rx_data);
      if (rx_valid && rx_full_m) m_rx_overrun = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic [7:0] second_rx;
    m_tx_drop    = 1'b0;
    m_rx_overrun = 1'b0;
    set_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    apply_stimulus();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus();
    check_output("reset_tx_valid",  32'(tx_valid),  32'd0);
    check_output("reset_in_stall",  32'(in_stall),  32'd1);
    check_output("reset_out_stall", 32'(out_stall), 32'd0);
    check_output("reset_counts",    32'({tx_count, rx_count}), 32'd0);
    check_output("reset_flags",     32'({tx_drop, rx_overrun}), 32'd0);

    $display("[TB] single TX byte");
    out_issued = 1'b1; out_data = 32'h1234_56A5;
    apply_stimulus();
    out_issued = 1'b0;
    check_output("tx_first_valid", 32'(tx_valid), 32'd1);
    check_output("tx_first_data",  32'(tx_data),  32'h0000_00A5);
    check_output("tx_first_count", 32'(tx_count), 32'd1);
    tx_ready = 1'b1;
    apply_stimulus();
    tx_ready = 1'b0;
    check_output("tx_first_gone",  32'({tx_valid, tx_count}), 32'd0);

    $display("[TB] TX fill, drop and drain");
    for (int i = 0; i < 16; i++) begin
      out_issued = 1'b1; out_data = 32'(i);
      apply_stimulus();
    end
    check_output("tx_full_stall", 32'(out_stall), 32'd1);
    check_output("tx_full_count", 32'(tx_count),  32'd16);
    out_data = 32'h0000_00FF;
    apply_stimulus();
    out_issued = 1'b0;
    check_output("tx_drop_set",   32'(tx_drop),   32'd1);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_output("tx_drain_order", 32'(tx_data), 32'(i));
      apply_stimulus();
    end
    check_output("tx_drained", 32'(tx_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      out_issued = 1'b1; out_data = 32'($urandom);
      apply_stimulus();
    end
    out_issued = 1'b0;
    apply_stimulus();
    tx_ready = 1'b0;

    $display("[TB] RX single byte");
    in_issued = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h7E;
    apply_stimulus();
    rx_valid = 1'b0;
    check_output("rx_first_stall", 32'(in_stall), 32'd0);
    check_output("rx_first_data",  in_data,       32'h0000_007E);
    apply_stimulus();
    in_issued = 1'b0;
    check_output("rx_first_popped", 32'({in_stall, rx_count}), 32'h20);

    $display("[TB] RX overrun with simultaneous pop");
    second_rx = '0;
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom);
      if (i == 1) second_rx = rx_data;
      apply_stimulus();
    end
    in_issued = 1'b1; rx_data = 8'hC3;
    apply_stimulus();
    rx_valid = 1'b0; in_issued = 1'b0;
    check_output("rx_overrun_set", 32'(rx_overrun), 32'd1);
    check_output("rx_overrun_cnt", 32'(rx_count),   32'd15);
    check_output("rx_overrun_head", in_data,        32'(second_rx));

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 16; i++) begin
      out_issued = 1'b1; out_data = 32'($urandom);
      apply_stimulus();
    end
    out_issued = 1'b0;
    tx_ready = 1'b1;
    apply_stimulus();
    apply_stimulus();
    rst = 1'b0;
    apply_stimulus();
    rst = 1'b1;
    check_output("rst_tx_valid",  32'(tx_valid),  32'd0);
    check_output("rst_tx_count",  32'(tx_count),  32'd0);
    check_output("rst_tx_drop",   32'(tx_drop),   32'd0);
    check_output("rst_out_stall", 32'(out_stall), 32'd0);
    tx_ready = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      out_issued = (tx_q.size() != 16) && ($urandom_range(0, 2) == 0);
      out_data   = $urandom;
      tx_ready   = ($urandom_range(0, 2) == 0);
      in_issued  = ($urandom_range(0, 2) == 0);
      rx_valid   = ($urandom_range(0, 1) == 0);
      rx_data    = 8'($urandom);
      rst        = ($urandom_range(0, 299) != 0);
      apply_stimulus();
    end
    set_idle();
    rst = 1'b1;
    apply_stimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
